axis_video_pattern_gen: RTL and testbench
=========================================

// Module: axis_video_pattern_gen
// PURPOSE
//  Synthetic AXI4-Stream video source placed directly upstream of stream_video_filter.
//  Generates frames of FRAME_WIDTH x FRAME_HEIGHT 24-bit pixels, with tuser = start of frame
//  and tlast = end of line, and fully honours tready backpressure.
//  Provides known-content stimulus for filter bring-up in simulation and on hardware.
// PARAMETERS
//  FRAME_WIDTH   20  pixels per line (>=8)
//  FRAME_HEIGHT  10  lines per frame (>=2)
//  LINE_GAP      0   idle cycles (tvalid=0) inserted after every accepted tlast beat, 0..255
//  CHECK_LOG2    2   checkerboard square size = 2**CHECK_LOG2 pixels
// PORTS
//  clk                  in   1   clock
//  rst                  in   1   reset, synchronous, active-low
//  enable               in   1   1 = run frames continuously; 0 = stop at next frame boundary
//  pattern_sel          in   2   0 ramp, 1 colour bars, 2 checkerboard, 3 frame-counter flat
//  m_axis_video_tdata   out  24  pixel {R[23:16],G[15:8],B[7:0]}
//  m_axis_video_tvalid  out  1   pixel valid
//  m_axis_video_tready  in   1   downstream ready
//  m_axis_video_tuser   out  1   1 on pixel (x=0,y=0) only
//  m_axis_video_tlast   out  1   1 on pixel x=FRAME_WIDTH-1
//  frame_done           out  1   1-cycle pulse after last pixel of a frame is accepted
//  frame_cnt            out  8   completed frames, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; x, y, gap, frame_cnt = 0; all outputs 0.
//   Reset in mid-frame abandons that frame; the next frame starts at (0,0) with tuser=1.
//  Transfer = tvalid & tready at posedge. All outputs are registered.
//  FSM IDLE -> ACTIVE: enable=1 at edge N -> tvalid=1 with pixel (0,0) and tuser=1 after edge N.
//   pattern_sel is latched at that same edge and held for the whole frame.
//  ACTIVE: once tvalid=1, tdata/tuser/tlast stay stable until a transfer occurs (AXI rule).
//   On each transfer, advance x; on the x=FRAME_WIDTH-1 transfer: x=0, y++.
//   After a tlast transfer with LINE_GAP>0 -> GAP (tvalid=0 for exactly LINE_GAP cycles),
//   then ACTIVE with the next pixel. LINE_GAP=0 gives back-to-back beats with no bubble.
//  End of frame = transfer at (FRAME_WIDTH-1, FRAME_HEIGHT-1): frame_done=1 for the next cycle;
//   frame_cnt++; y=0. Line gap applies here as well.
//   Then, if enable=1, start the next frame: tuser=1, pattern_sel re-latched.
//   Otherwise go to IDLE with tvalid=0.
//  enable=0 mid-frame has no effect until the frame completes; frames are never truncated.
//  Pixel content (x, y = position; f = frame_cnt at frame start):
//   0 ramp:    R = x[7:0], G = y[7:0], B = f.
//   1 bars:    bar = min(x / (FRAME_WIDTH/8), 7) (integer division).
//              Colours: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
//   2 checker: (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? FFFFFF : 000000.
//   3 flat:    {f, f, f}.
//  Counters x and y are wide enough for FRAME_WIDTH and FRAME_HEIGHT. Only bits [7:0] feed
//   the ramp pattern (wrap modulo 256).
//  tready=0 for any length stalls the generator; no pixel is skipped or duplicated.
// TESTING
//  1 rst=0 for 3 cycles, then rst=1, enable=1, tready=1, sel=0 -> 200 beats.
//    First beat tdata=000000 with tuser=1; tlast on beats 20,40,...,200;
//    beat 21 = 000100; frame_done pulse after beat 200; frame_cnt=1.
//  2 sel=1, tready=1 -> line 0: x=0,1 FFFFFF; x=2,3 FFFF00; x=12,13 0000FF; x=14..19 000000.
//  3 sel=2, CHECK_LOG2=2 -> (0,0)=000000, (4,0)=FFFFFF, (4,4)=000000; the pattern repeats every 8.
//  4 random tready (~50%) for 3 frames -> tdata/tuser/tlast held while stalled.
//    The bench model checks exactly 600 beats in raster order; frame_cnt=3.
//  5 LINE_GAP=3 -> exactly 3 tvalid=0 cycles after every tlast transfer, none elsewhere.
//  6 enable=0 at pixel (5,4) -> frame completes to (19,9), then tvalid=0 and IDLE.
//    rst=0 mid-frame -> outputs 0 next cycle; after release the next beat has tuser=1, tdata(0,0).

Source files
------------

// File: rtl/axis_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// axis_video_pattern_gen
//
// Synthetic AXI4-Stream video source. Emits frames of FRAME_WIDTH x
// FRAME_HEIGHT 24-bit pixels in raster order. tuser marks the first pixel of
// a frame and tlast marks the last pixel of each line. tready backpressure is
// fully honoured: a presented beat is held unchanged until it is accepted.
//
// Parameters
//   FRAME_WIDTH   pixels per line (>= 8)
//   FRAME_HEIGHT  lines per frame (>= 2)
//   LINE_GAP      idle cycles (tvalid=0) after every accepted tlast beat, 0..255
//   CHECK_LOG2    checkerboard square size is 2**CHECK_LOG2 pixels
//
// Ports
//   clk                  in   clock
//   rst                  in   synchronous reset, active-low
//   enable               in   1 = run frames back to back, 0 = stop at the next
//                             frame boundary (a frame is never truncated)
//   pattern_sel          in   0 ramp, 1 colour bars, 2 checkerboard, 3 flat
//   m_axis_video_tdata   out  pixel {R[23:16], G[15:8], B[7:0]}
//   m_axis_video_tvalid  out  pixel valid
//   m_axis_video_tready  in   downstream ready
//   m_axis_video_tuser   out  start of frame, pixel (0,0) only
//   m_axis_video_tlast   out  end of line, pixel x = FRAME_WIDTH-1
//   frame_done           out  one-cycle pulse after the last pixel is accepted
//   frame_cnt            out  completed frame count, wraps 255 -> 0
//
// All outputs come straight from registers. The pixel for the next position
// is computed in the same cycle as the transfer that advances to it, so there
// is never a bubble when LINE_GAP = 0.
// ---------------------------------------------------------------------------
module axis_video_pattern_gen #(
    parameter int FRAME_WIDTH  = 20,
    parameter int FRAME_HEIGHT = 10,
    parameter int LINE_GAP     = 0,
    parameter int CHECK_LOG2   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int BAR_W = FRAME_WIDTH / 8;

    localparam logic [XW-1:0] X_LAST   = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(FRAME_HEIGHT - 1);
    // The gap counter is loaded with LINE_GAP-1 and the state leaves GAP on
    // the edge where it reads zero, giving exactly LINE_GAP idle cycles.
    localparam logic [7:0]    GAP_INIT = 8'((LINE_GAP > 0) ? (LINE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [7:0]      gap_q;
    logic [1:0]      sel_q;        // pattern latched at frame start
    logic [7:0]      f_q;          // frame_cnt value latched at frame start
    logic [7:0]      frame_cnt_q;
    logic [23:0]     tdata_q;
    logic            tvalid_q;
    logic            tuser_q;
    logic            tlast_q;
    logic            done_q;

    // Position and count that follow an accepted beat at (x_q, y_q)
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic [7:0]      frame_cnt_d;
    logic            eol;
    logic            eof;
    logic            xfer;

    // -----------------------------------------------------------------------
    // Pixel content for a given position. The arithmetic is carried out on
    // 32-bit copies of the coordinates so that the ramp can take bits [7:0]
    // and the checkerboard can take bit CHECK_LOG2 regardless of the counter
    // widths chosen for the frame size.
    // -----------------------------------------------------------------------
    function automatic logic [23:0] pixel(
        input logic [1:0]    sel,
        input logic [XW-1:0] px,
        input logic [YW-1:0] py,
        input logic [7:0]    f
    );
        logic [31:0] xe;
        logic [31:0] ye;
        logic [31:0] bar;
        logic [31:0] chk;
        logic [23:0] p;
        xe  = 32'(px);
        ye  = 32'(py);
        bar = xe / 32'(BAR_W);
        if (bar > 32'd7) begin
            bar = 32'd7;
        end
        chk = ((xe ^ ye) >> CHECK_LOG2) & 32'd1;
        p   = 24'h000000;
        case (sel)
            2'd0: p = {xe[7:0], ye[7:0], f};
            2'd1: begin
                case (bar[2:0])
                    3'd0:    p = 24'hFFFFFF;
                    3'd1:    p = 24'hFFFF00;
                    3'd2:    p = 24'h00FFFF;
                    3'd3:    p = 24'h00FF00;
                    3'd4:    p = 24'hFF00FF;
                    3'd5:    p = 24'hFF0000;
                    3'd6:    p = 24'h0000FF;
                    default: p = 24'h000000;
                endcase
            end
            2'd2:    p = (chk != 32'd0) ? 24'hFFFFFF : 24'h000000;
            default: p = {f, f, f};
        endcase
        return p;
    endfunction

    always_comb begin
        xfer        = tvalid_q & m_axis_video_tready;
        eol         = (x_q == X_LAST);
        eof         = eol && (y_q == Y_LAST);
        x_d         = eol ? '0 : (x_q + XW'(1));
        y_d         = eof ? '0 : (eol ? (y_q + YW'(1)) : y_q);
        frame_cnt_d = eof ? (frame_cnt_q + 8'd1) : frame_cnt_q;
    end

    // -----------------------------------------------------------------------
    // Control FSM and output registers.
    // A new frame always begins at (0,0) with tuser=1, and re-samples
    // pattern_sel and the frame count on that same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            gap_q       <= 8'd0;
            sel_q       <= 2'd0;
            f_q         <= 8'd0;
            frame_cnt_q <= 8'd0;
            tdata_q     <= 24'h000000;
            tvalid_q    <= 1'b0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q  <= S_ACTIVE;
                        x_q      <= '0;
                        y_q      <= '0;
                        sel_q    <= pattern_sel;
                        f_q      <= frame_cnt_q;
                        tdata_q  <= pixel(pattern_sel, '0, '0, frame_cnt_q);
                        tvalid_q <= 1'b1;
                        tuser_q  <= 1'b1;
                        tlast_q  <= (X_LAST == '0);
                    end
                end

                S_ACTIVE: begin
                    // Outputs are only touched on a transfer, which keeps the
                    // beat stable for as long as tready is held low.
                    if (xfer) begin
                        x_q         <= x_d;
                        y_q         <= y_d;
                        frame_cnt_q <= frame_cnt_d;
                        if (eof) begin
                            done_q <= 1'b1;
                        end
                        if (eol && (LINE_GAP > 0)) begin
                            state_q  <= S_GAP;
                            gap_q    <= GAP_INIT;
                            tvalid_q <= 1'b0;
                            tuser_q  <= 1'b0;
                            tlast_q  <= 1'b0;
                        end else if (eof) begin
                            if (enable) begin
                                sel_q    <= pattern_sel;
                                f_q      <= frame_cnt_d;
                                tdata_q  <= pixel(pattern_sel, '0, '0, frame_cnt_d);
                                tuser_q  <= 1'b1;
                                tlast_q  <= (X_LAST == '0);
                            end else begin
                                state_q  <= S_IDLE;
                                tvalid_q <= 1'b0;
                                tuser_q  <= 1'b0;
                                tlast_q  <= 1'b0;
                            end
                        end else begin
                            tdata_q <= pixel(sel_q, x_d, y_d, f_q);
                            tuser_q <= 1'b0;
                            tlast_q <= (x_d == X_LAST);
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == 8'd0) begin
                        // Position (0,0) here can only follow an end of frame,
                        // so this is where the next frame is decided.
                        if ((x_q == '0) && (y_q == '0)) begin
                            if (enable) begin
                                state_q  <= S_ACTIVE;
                                sel_q    <= pattern_sel;
                                f_q      <= frame_cnt_q;
                                tdata_q  <= pixel(pattern_sel, '0, '0, frame_cnt_q);
                                tvalid_q <= 1'b1;
                                tuser_q  <= 1'b1;
                                tlast_q  <= (X_LAST == '0);
                            end else begin
                                state_q  <= S_IDLE;
                            end
                        end else begin
                            state_q  <= S_ACTIVE;
                            tdata_q  <= pixel(sel_q, x_q, y_q, f_q);
                            tvalid_q <= 1'b1;
                            tuser_q  <= 1'b0;
                            tlast_q  <= (x_q == X_LAST);
                        end
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    tvalid_q <= 1'b0;
                    tuser_q  <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_video_tdata  = tdata_q;
    assign m_axis_video_tvalid = tvalid_q;
    assign m_axis_video_tuser  = tuser_q;
    assign m_axis_video_tlast  = tlast_q;
    assign frame_done          = done_q;
    assign frame_cnt           = frame_cnt_q;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// Bench for axis_video_pattern_gen.
// dut0: LINE_GAP=0, driven through a sequence of frames; every accepted beat
//       is compared in order against an expected-beat queue.
// dut1: LINE_GAP=3, tready tied high, two frames; idle-cycle runs between
//       beats and tlast/tuser placement are checked.
// ---------------------------------------------------------------------------
module tb_axis_video_pattern_gen;

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [1:0]  sel;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    logic        rst1;
    logic        enable1;
    logic [23:0] tdata1;
    logic        tvalid1;
    logic        tready1;
    logic        tuser1;
    logic        tlast1;
    logic        frame_done1;
    logic [7:0]  frame_cnt1;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          beat_cnt = 0;
    bit          rmode = 0;
    beat_t       exp_q[$];

    logic [23:0] cap_d [0:4095];
    logic        cap_u [0:4095];
    logic        cap_l [0:4095];

    bit          hold_chk = 0;
    logic [23:0] hold_d;
    logic        hold_u;
    logic        hold_l;

    int          beats1 = 0;
    int          idle_run1 = 0;
    int          gaps1 = 0;
    bit          seen1 = 0;
    bit          after_last1 = 0;

    axis_video_pattern_gen #(
        .FRAME_WIDTH(20), .FRAME_HEIGHT(10), .LINE_GAP(0), .CHECK_LOG2(2)
    ) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(sel),
        .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
        .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
        .m_axis_video_tlast(tlast), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    axis_video_pattern_gen #(
        .FRAME_WIDTH(20), .FRAME_HEIGHT(10), .LINE_GAP(3), .CHECK_LOG2(2)
    ) dut1 (
        .clk(clk), .rst(rst1), .enable(enable1), .pattern_sel(2'd0),
        .m_axis_video_tdata(tdata1), .m_axis_video_tvalid(tvalid1),
        .m_axis_video_tready(tready1), .m_axis_video_tuser(tuser1),
        .m_axis_video_tlast(tlast1), .frame_done(frame_done1), .frame_cnt(frame_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pixel, written from the pattern definitions.
    function automatic logic [23:0] exp_pix(input int s, input int x, input int y, input int f);
        int bar;
        logic [7:0] xb, yb, fb;
        xb = 8'(x);
        yb = 8'(y);
        fb = 8'(f);
        case (s)
            0: return {xb, yb, fb};
            1: begin
                bar = x / 2;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((x / 4) + (y / 4)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return {fb, fb, fb};
        endcase
    endfunction

    task automatic push_frame(input int s, input int f);
        beat_t b;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 20; x++) begin
                b.d = exp_pix(s, x, y, f);
                b.u = (x == 0 && y == 0);
                b.l = (x == 19);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic wait_beats(input int target, input string name);
        for (int i = 0; i < 5000 && beat_cnt < target; i++) @(negedge clk);
        if (beat_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: beats %0d want %0d", name, beat_cnt, target);
        end
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: frame_done got none want pulse", name);
        end
    endtask

    // tready driver: constant 1, or ~50% random while rmode is set
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // dut0 monitor: scoreboard pop on every transfer, hold check while stalled
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (hold_chk) begin
                n_cmp++;
                if (!tvalid || tdata !== hold_d || tuser !== hold_u || tlast !== hold_l) begin
                    n_bad++;
                    $display("FAIL hold: got v=%b d=%h u=%b l=%b want v=1 d=%h u=%b l=%b",
                             tvalid, tdata, tuser, tlast, hold_d, hold_u, hold_l);
                end
            end
            if (tvalid && tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat %0d: got d=%h u=%b l=%b want no beat", beat_cnt, tdata, tuser, tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e.d || tuser !== e.u || tlast !== e.l) begin
                        n_bad++;
                        $display("FAIL beat %0d: got d=%h u=%b l=%b want d=%h u=%b l=%b",
                                 beat_cnt, tdata, tuser, tlast, e.d, e.u, e.l);
                    end
                end
                if (beat_cnt < 4096) begin
                    cap_d[beat_cnt] = tdata;
                    cap_u[beat_cnt] = tuser;
                    cap_l[beat_cnt] = tlast;
                end
                beat_cnt++;
            end
            hold_chk = tvalid && !tready;
            hold_d   = tdata;
            hold_u   = tuser;
            hold_l   = tlast;
        end else begin
            hold_chk = 0;
        end
    end

    // dut1 monitor: idle run before each beat must be 3 after a tlast, else 0
    always @(negedge clk) begin
        if (rst1) begin
            if (tvalid1) begin
                if (seen1) begin
                    n_cmp++;
                    if (after_last1) gaps1++;
                    if (idle_run1 != (after_last1 ? 3 : 0)) begin
                        n_bad++;
                        $display("FAIL gap before beat %0d: got %0d idle want %0d",
                                 beats1, idle_run1, after_last1 ? 3 : 0);
                    end
                end
                seen1 = 1;
                beats1++;
                n_cmp++;
                if (tlast1 !== (beats1 % 20 == 0) || tuser1 !== (beats1 % 200 == 1)) begin
                    n_bad++;
                    $display("FAIL gap_dut beat %0d: got l=%b u=%b want l=%b u=%b",
                             beats1, tlast1, tuser1, beats1 % 20 == 0, beats1 % 200 == 1);
                end
                after_last1 = tlast1;
                idle_run1 = 0;
            end else if (seen1) begin
                idle_run1++;
            end
        end
    end

    // dut1 control: two frames, enable dropped during the second
    initial begin
        tready1 = 1'b1;
        enable1 = 1'b0;
        rst1    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst1    = 1'b1;
        enable1 = 1'b1;
        for (int i = 0; i < 3000 && beats1 < 210; i++) @(negedge clk);
        enable1 = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst    = 1'b0;
        enable = 1'b0;
        sel    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // Frame 0: ramp, full-rate
        rst    = 1'b1;
        enable = 1'b1;
        sel    = 2'd0;
        push_frame(0, 0);
        wait_beats(1, "f0_start");
        sel = 2'd1;
        push_frame(1, 1);
        wait_done("f0_done");
        chk("f0_frame_cnt", frame_cnt, 1);
        chk("f0_first_d", cap_d[0], 24'h000000);
        chk("f0_first_u", cap_u[0], 1);
        chk("f0_beat2_u", cap_u[1], 0);
        chk("f0_beat21_d", cap_d[20], 24'h000100);
        chk("f0_beat19_l", cap_l[18], 0);
        chk("f0_beat20_l", cap_l[19], 1);
        chk("f0_beat200_l", cap_l[199], 1);
        @(negedge clk);
        chk("f0_done_width", frame_done, 0);

        // Frame 1: colour bars
        wait_beats(201, "f1_start");
        sel = 2'd2;
        push_frame(2, 2);
        wait_done("f1_done");
        chk("f1_frame_cnt", frame_cnt, 2);
        chk("bars_x0", cap_d[200], 24'hFFFFFF);
        chk("bars_x1", cap_d[201], 24'hFFFFFF);
        chk("bars_x2", cap_d[202], 24'hFFFF00);
        chk("bars_x3", cap_d[203], 24'hFFFF00);
        chk("bars_x12", cap_d[212], 24'h0000FF);
        chk("bars_x13", cap_d[213], 24'h0000FF);
        for (int x = 14; x < 20; x++) chk("bars_tail", cap_d[200 + x], 24'h000000);

        // Frame 2: checkerboard; frames 3..5 flat under random backpressure
        wait_beats(401, "f2_start");
        sel = 2'd3;
        push_frame(3, 3);
        push_frame(3, 4);
        push_frame(3, 5);
        wait_done("f2_done");
        chk("f2_frame_cnt", frame_cnt, 3);
        chk("chk_0_0", cap_d[400], 24'h000000);
        chk("chk_4_0", cap_d[404], 24'hFFFFFF);
        chk("chk_4_4", cap_d[484], 24'h000000);
        chk("chk_0_4", cap_d[480], 24'hFFFFFF);
        chk("chk_8_0", cap_d[408], 24'h000000);
        rmode = 1;
        wait_done("f3_done");
        wait_done("f4_done");
        chk("f4_frame_cnt", frame_cnt, 5);
        sel = 2'd0;
        push_frame(0, 6);
        wait_done("f5_done");
        chk("f5_frame_cnt", frame_cnt, 6);
        rmode = 0;

        // Frame 6: enable dropped at pixel (5,4); frame must still complete
        wait_beats(1285, "f6_mid");
        enable = 1'b0;
        wait_done("f6_done");
        chk("f6_frame_cnt", frame_cnt, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_tvalid", tvalid, 0);
        end
        chk("beats_total", beat_cnt, 1400);
        chk("queue_empty_idle", exp_q.size(), 0);

        // Frame 7 abandoned by a mid-frame reset
        enable = 1'b1;
        sel    = 2'd0;
        push_frame(0, 7);
        wait_beats(1450, "f7_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_tvalid", tvalid, 0);
        chk("mrst_tdata", tdata, 0);
        chk("mrst_tuser", tuser, 0);
        chk("mrst_tlast", tlast, 0);
        chk("mrst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        push_frame(0, 0);
        base = beat_cnt;
        rst  = 1'b1;
        wait_beats(base + 1, "post_rst_start");
        enable = 1'b0;
        chk("post_rst_first_d", cap_d[base], 24'h000000);
        chk("post_rst_first_u", cap_u[base], 1);
        wait_done("post_rst_done");
        chk("post_rst_frame_cnt", frame_cnt, 1);
        repeat (3) @(negedge clk);
        chk("post_rst_idle", tvalid, 0);
        chk("queue_empty_end", exp_q.size(), 0);

        // Line-gap instance
        chk("gap_dut_beats", beats1, 400);
        chk("gap_dut_gaps", gaps1, 19);
        chk("gap_dut_frame_cnt", frame_cnt1, 2);
        chk("gap_dut_idle", tvalid1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
